keyboard_movement_decoder: RTL and testbench



---
 rtl/keyboard_movement_decoder_pkg.sv | 62 ++++++
 rtl/keyboard_movement_decoder_ps2_rx_frame.sv | 114 +++++++++++
 rtl/keyboard_movement_decoder.sv | 115 +++++++++++
 tb/tb_keyboard_movement_decoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keyboard_movement_decoder_pkg.sv
// Scancodes, decoder state type and key-mask helpers shared by the
// keyboard movement decoder and its PS/2 frame receiver.
package keyboard_movement_decoder_pkg;

    // Set-2 scancodes of interest
    localparam logic [7:0] KC_EXT   = 8'hE0;
    localparam logic [7:0] KC_BRK   = 8'hF0;
    localparam logic [7:0] KC_UP    = 8'h75;
    localparam logic [7:0] KC_DOWN  = 8'h72;
    localparam logic [7:0] KC_LEFT  = 8'h6B;
    localparam logic [7:0] KC_RIGHT = 8'h74;
    localparam logic [7:0] KC_KP8   = 8'h75;
    localparam logic [7:0] KC_KP2   = 8'h72;
    localparam logic [7:0] KC_KP4   = 8'h6B;
    localparam logic [7:0] KC_KP6   = 8'h74;
    localparam logic [7:0] KC_OVR0  = 8'h00;
    localparam logic [7:0] KC_OVR1  = 8'hFF;

    // Bit positions inside the 4-bit held-key vector
    localparam int KEY_RIGHT = 0;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_FWD   = 2;
    localparam int KEY_BACK  = 3;

    localparam int FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GOT_E0,
        ST_GOT_F0,
        ST_GOT_E0F0
    } dec_state_e;

    // Extended (E0-prefixed) arrow code -> key mask
    function automatic logic [3:0] arrow_mask(input logic [7:0] code);
        logic [3:0] m;
        m = 4'b0000;
        case (code)
            KC_UP:    m[KEY_FWD]   = 1'b1;
            KC_DOWN:  m[KEY_BACK]  = 1'b1;
            KC_LEFT:  m[KEY_LEFT]  = 1'b1;
            KC_RIGHT: m[KEY_RIGHT] = 1'b1;
            default:  m = 4'b0000;
        endcase
        return m;
    endfunction

    // Non-extended keypad arrow code -> key mask
    function automatic logic [3:0] keypad_mask(input logic [7:0] code);
        logic [3:0] m;
        m = 4'b0000;
        case (code)
            KC_KP8:  m[KEY_FWD]   = 1'b1;
            KC_KP2:  m[KEY_BACK]  = 1'b1;
            KC_KP4:  m[KEY_LEFT]  = 1'b1;
            KC_KP6:  m[KEY_RIGHT] = 1'b1;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/keyboard_movement_decoder_ps2_rx_frame.sv
// PS/2 frame receiver: synchronises the raw lines, shifts in 11-bit
// frames on ps2_clk falling edges, checks start/parity/stop and times out
// stalled frames.
//   clock, reset        : system clock, synchronous active-high reset
//   ps2_clk, ps2_dat    : raw asynchronous PS/2 lines
//   byte_valid          : 1-cycle strobe, good frame received
//   byte_data           : last good byte, held between frames
//   frame_error         : 1-cycle strobe, bad frame or timeout
module keyboard_movement_decoder_ps2_rx_frame
    import keyboard_movement_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          clk_prev_q;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [7:0]    data_q, data_d;

    logic fall;
    logic bit_dat;
    logic frame_ok;

    // Idle-high lines: reset the synchronisers to 1 so no false edge fires
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_dat};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign fall    = clk_prev_q & ~clk_sync_q[1];
    assign bit_dat = dat_sync_q[1];

    // shift_q[0] is the start bit, [8:1] data, [9] parity; stop is live
    assign frame_ok = ~shift_q[0] & (^shift_q[9:1]) & bit_dat;

    always_comb begin
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tmo_d     = tmo_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        data_d    = data_q;
        if (fall) begin
            tmo_d = '0;
            if (bit_idx_q == LAST_BIT) begin
                bit_idx_d = 4'd0;
                if (frame_ok) begin
                    valid_d = 1'b1;
                    data_d  = shift_q[8:1];
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                shift_d   = {bit_dat, shift_q[9:1]};
                bit_idx_d = bit_idx_q + 4'd1;
            end
        end else if (bit_idx_q != 4'd0) begin
            if (tmo_q == TMO_LAST) begin
                tmo_d     = '0;
                bit_idx_d = 4'd0;
                err_d     = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_idx_q <= 4'd0;
            shift_q   <= '0;
            tmo_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tmo_q     <= tmo_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            data_q    <= data_d;
        end
    end

    assign byte_valid  = valid_q;
    assign byte_data   = data_q;
    assign frame_error = err_q;

endmodule

// File: rtl/keyboard_movement_decoder.sv
// PS/2 keyboard -> held arrow-key levels for player_updater.
// Ports:
//   clock, reset        : 50 MHz clock, synchronous active-high reset
//   ps2_clk, ps2_dat    : raw asynchronous PS/2 lines
//   turn_right/turn_left/move_forward/move_backward : held-key levels
//   byte_valid, byte_data, frame_error : receiver status
module keyboard_movement_decoder
    import keyboard_movement_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int ACCEPT_KEYPAD  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       turn_right,
    output logic       turn_left,
    output logic       move_forward,
    output logic       move_backward,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_error
);

    localparam bit KP_EN = (ACCEPT_KEYPAD != 0);

    dec_state_e state_q, state_d;
    logic [3:0] keys_q, keys_d;
    logic [3:0] ext_m;
    logic [3:0] kp_m;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       overrun;

    keyboard_movement_decoder_ps2_rx_frame #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .byte_valid (rx_valid),
        .byte_data  (rx_data),
        .frame_error(rx_err)
    );

    assign ext_m   = arrow_mask(rx_data);
    assign kp_m    = KP_EN ? keypad_mask(rx_data) : 4'b0000;
    assign overrun = (rx_data == KC_OVR0) || (rx_data == KC_OVR1);

    always_comb begin
        state_d = state_q;
        keys_d  = keys_q;
        if (rx_err) begin
            // Partial prefix is meaningless after a bad frame
            state_d = ST_IDLE;
        end else if (rx_valid) begin
            if (overrun) begin
                keys_d  = 4'b0000;
                state_d = ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (rx_data == KC_EXT) begin
                            state_d = ST_GOT_E0;
                        end else if (rx_data == KC_BRK) begin
                            state_d = ST_GOT_F0;
                        end else begin
                            keys_d = keys_q | kp_m;
                        end
                    end
                    ST_GOT_E0: begin
                        // A repeated E0 keeps the extended prefix alive
                        if (rx_data == KC_BRK) begin
                            state_d = ST_GOT_E0F0;
                        end else if (rx_data != KC_EXT) begin
                            keys_d  = keys_q | ext_m;
                            state_d = ST_IDLE;
                        end
                    end
                    ST_GOT_F0: begin
                        keys_d  = keys_q & ~kp_m;
                        state_d = ST_IDLE;
                    end
                    ST_GOT_E0F0: begin
                        keys_d  = keys_q & ~ext_m;
                        state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            keys_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            keys_q  <= keys_d;
        end
    end

    assign turn_right    = keys_q[KEY_RIGHT];
    assign turn_left     = keys_q[KEY_LEFT];
    assign move_forward  = keys_q[KEY_FWD];
    assign move_backward = keys_q[KEY_BACK];
    assign byte_valid    = rx_valid;
    assign byte_data     = rx_data;
    assign frame_error   = rx_err;

endmodule

// File: tb/tb_keyboard_movement_decoder.sv
// Randomised self-checking bench: two decoders (keypad on/off) share the
// PS/2 lines and are compared against a flag-based behavioural model.
module tb_keyboard_movement_decoder;

    localparam int TMO = 400;
    localparam int H   = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;

    logic right_a, left_a, fwd_a, back_a, bv_a, fe_a;
    logic right_b, left_b, fwd_b, back_b, bv_b, fe_b;
    logic [7:0] data_a, data_b;
    logic [3:0] keys_a, keys_b;

    int checks = 0;
    int failures = 0;
    int nbv = 0;
    int nfe = 0;

    logic [3:0] mkeys [2];
    bit         mext  [2];
    bit         mbrk  [2];

    always #5 clock = ~clock;

    keyboard_movement_decoder #(.TIMEOUT_CYCLES(TMO), .ACCEPT_KEYPAD(1)) dut_a (
        .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .turn_right(right_a), .turn_left(left_a),
        .move_forward(fwd_a), .move_backward(back_a),
        .byte_valid(bv_a), .byte_data(data_a), .frame_error(fe_a)
    );

    keyboard_movement_decoder #(.TIMEOUT_CYCLES(TMO), .ACCEPT_KEYPAD(0)) dut_b (
        .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .turn_right(right_b), .turn_left(left_b),
        .move_forward(fwd_b), .move_backward(back_b),
        .byte_valid(bv_b), .byte_data(data_b), .frame_error(fe_b)
    );

    assign keys_a = {back_a, fwd_a, left_a, right_a};
    assign keys_b = {back_b, fwd_b, left_b, right_b};

    always @(negedge clock) begin
        if (bv_a) nbv++;
        if (fe_a) nfe++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {back, fwd, left, right}
    function automatic logic [3:0] key_of(input logic [7:0] b);
        if (b == 8'h75) return 4'b0100;
        if (b == 8'h72) return 4'b1000;
        if (b == 8'h6B) return 4'b0010;
        if (b == 8'h74) return 4'b0001;
        return 4'b0000;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mkeys[m] = 4'b0000;
            mext[m]  = 1'b0;
            mbrk[m]  = 1'b0;
        end
    endtask

    task automatic model_err();
        for (int m = 0; m < 2; m++) begin
            mext[m] = 1'b0;
            mbrk[m] = 1'b0;
        end
    endtask

    // m=0 accepts keypad arrows, m=1 does not
    task automatic model_byte(input logic [7:0] b);
        logic [3:0] k;
        for (int m = 0; m < 2; m++) begin
            if (b == 8'h00 || b == 8'hFF) begin
                mkeys[m] = 4'b0000;
                mext[m]  = 1'b0;
                mbrk[m]  = 1'b0;
            end else if (b == 8'hE0 && !mbrk[m]) begin
                mext[m] = 1'b1;
            end else if (b == 8'hF0 && !mbrk[m]) begin
                mbrk[m] = 1'b1;
            end else begin
                k = key_of(b);
                if (mext[m] || m == 0) begin
                    if (mbrk[m]) mkeys[m] = mkeys[m] & ~k;
                    else         mkeys[m] = mkeys[m] | k;
                end
                mext[m] = 1'b0;
                mbrk[m] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset   = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit bad_stop, input int nbits);
        logic [10:0] f;
        int nb0, ne0, lat;
        bit good;
        f    = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        good = !bad_par && !bad_stop;
        nb0  = nbv;
        ne0  = nfe;
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = f[i];
            repeat (H) @(negedge clock);
            ps2_clk = 1'b0;
            if (i == 10) begin
                lat = 0;
                for (int c = 1; c <= 6 && lat == 0; c++) begin
                    @(negedge clock);
                    if (bv_a || fe_a) lat = c;
                end
                check("latency", 32'(lat != 0 && lat <= 4), 32'd1);
                if (good) begin
                    check("byte_valid", 32'(bv_a), 32'd1);
                    check("byte_data", 32'(data_a), 32'(b));
                    check("keys_a_pre", 32'(keys_a), 32'(mkeys[0]));
                    check("keys_b_pre", 32'(keys_b), 32'(mkeys[1]));
                    model_byte(b);
                end else begin
                    check("frame_error", 32'(fe_a), 32'd1);
                    model_err();
                end
                @(negedge clock);
                check("keys_a", 32'(keys_a), 32'(mkeys[0]));
                check("keys_b", 32'(keys_b), 32'(mkeys[1]));
            end
            repeat (H) @(negedge clock);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (2 * H) @(negedge clock);
        if (nbits == 11) begin
            check("bv_count", 32'(nbv - nb0), 32'(good));
            check("fe_count", 32'(nfe - ne0), 32'(!good));
        end
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11);
    endtask

    initial begin
        int nb0, ne0;
        logic [7:0] b;
        int r;
        logic [7:0] pool [9];
        pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h00, 8'hE1, 8'h1C};

        do_reset();
        check("rst_keys_a", 32'(keys_a), 32'd0);
        check("rst_keys_b", 32'(keys_b), 32'd0);
        check("rst_bv", 32'(bv_a), 32'd0);
        check("rst_fe", 32'(fe_a), 32'd0);
        check("rst_data", 32'(data_a), 32'd0);

        // Up make / break
        send(8'hE0); send(8'h75);
        check("up_held", 32'(fwd_a && fwd_b), 32'd1);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("up_rel", 32'(fwd_a || fwd_b), 32'd0);

        // Right + left together, release right only
        send(8'hE0); send(8'h74); send(8'hE0); send(8'h6B);
        check("rl_both", 32'(keys_a), 32'h3);
        send(8'hE0); send(8'hF0); send(8'h74);
        check("l_only", 32'(keys_a), 32'h2);
        send(8'hE0); send(8'hF0); send(8'h6B);

        // Bad parity / bad stop with Up held
        send(8'hE0); send(8'h75);
        send_frame(8'h75, 1'b1, 1'b0, 11);
        send_frame(8'h75, 1'b0, 1'b1, 11);
        check("bad_keep", 32'(keys_a), 32'h4);
        send(8'hE0); send(8'hF0); send(8'h75);

        // Timeout on a 6-bit fragment
        nb0 = nbv;
        ne0 = nfe;
        send_frame(8'h75, 1'b0, 1'b0, 6);
        repeat (TMO + 10) @(negedge clock);
        check("tmo_fe", 32'(nfe - ne0), 32'd1);
        check("tmo_bv", 32'(nbv - nb0), 32'd0);
        model_err();
        send(8'hE0); send(8'h72);
        check("tmo_back", 32'(back_a && back_b), 32'd1);
        send(8'hE0); send(8'hF0); send(8'h72);

        // Keypad Up
        send(8'h75);
        check("kp_a", 32'(fwd_a), 32'd1);
        check("kp_b", 32'(fwd_b), 32'd0);
        send(8'hF0); send(8'h75);
        check("kp_rel", 32'(fwd_a), 32'd0);

        // Overrun clears everything
        send(8'hE0); send(8'h75); send(8'h6B);
        send(8'hFF);
        check("ovr_a", 32'(keys_a), 32'd0);
        check("ovr_b", 32'(keys_b), 32'd0);

        // Reset between prefix and code
        send(8'hE0); send(8'h74);
        send(8'hE0);
        do_reset();
        check("mid_rst", 32'(keys_a), 32'd0);
        send(8'h72);
        check("no_back_b", 32'(back_b), 32'd0);

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 11));
            if (r < 9) b = pool[r];
            else       b = 8'($urandom);
            r = int'($urandom_range(0, 15));
            send_frame(b, r == 0, r == 1, 11);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
